// File: rtl/pc_seq_ctrl.sv
// Fetch/execute sequencer for the 4-bit CPU: drives the control pins of the cascaded
// 74HC161 program counter pair, handshakes instruction fetch and holds the instruction register.
module pc_seq_ctrl #(
    parameter int unsigned EXEC_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT  = 15,
    parameter logic [7:0]  RESET_VECTOR = 8'h00
) (
    input  logic       CP,
    input  logic       MRn,
    input  logic       run,
    input  logic       halt_req,
    input  logic [7:0] pc_q,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] ins_i,
    output logic [7:0] ir_o,
    input  logic       jmp_req,
    input  logic [7:0] jmp_addr,
    output logic       pc_pen_n,
    output logic       pc_cep,
    output logic       pc_cet,
    output logic [7:0] pc_d,
    output logic [2:0] state_o,
    output logic       err_o,
    output logic       wrap_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FETCH  = 3'd2,
        EXEC   = 3'd3,
        UPDATE = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [3:0] ACK_LIMIT = 4'(ACK_TIMEOUT);

    state_t     state, state_nx;
    logic [3:0] to_cnt, to_cnt_nx;
    logic [3:0] ex_cnt, ex_cnt_nx;
    logic [7:0] ir, ir_nx;
    logic       jmp_lat, jmp_lat_nx;
    logic [7:0] jmp_tgt, jmp_tgt_nx;
    logic       err, err_nx;
    logic       wrap, wrap_nx;

    always_ff @(posedge CP or negedge MRn) begin
        if (!MRn) begin
            state   <= IDLE;
            to_cnt  <= 4'd0;
            ex_cnt  <= 4'd0;
            ir      <= 8'h00;
            jmp_lat <= 1'b0;
            jmp_tgt <= 8'h00;
            err     <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nx;
            to_cnt  <= to_cnt_nx;
            ex_cnt  <= ex_cnt_nx;
            ir      <= ir_nx;
            jmp_lat <= jmp_lat_nx;
            jmp_tgt <= jmp_tgt_nx;
            err     <= err_nx;
            wrap    <= wrap_nx;
        end
    end

    // Counter pins depend only on registered state, so the counters act on the edge that ends the state.
    always_comb begin
        state_nx   = state;
        to_cnt_nx  = to_cnt;
        ex_cnt_nx  = ex_cnt;
        ir_nx      = ir;
        jmp_lat_nx = jmp_lat;
        jmp_tgt_nx = jmp_tgt;
        err_nx     = err;
        wrap_nx    = wrap;
        mem_req    = 1'b0;
        pc_pen_n   = 1'b1;
        pc_cep     = 1'b0;
        pc_d       = 8'h00;

        case (state)
            IDLE: begin
                if (run) state_nx = LOAD;
            end
            LOAD: begin
                pc_pen_n = 1'b0;
                pc_d     = RESET_VECTOR;
                state_nx = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_nx     = ins_i;
                    to_cnt_nx = 4'd0;
                    ex_cnt_nx = EXEC_LAST;
                    state_nx  = EXEC;
                end else if (to_cnt + 4'd1 == ACK_LIMIT) begin
                    to_cnt_nx = 4'd0;
                    err_nx    = 1'b1;
                    state_nx  = HALT;
                end else begin
                    to_cnt_nx = to_cnt + 4'd1;
                end
            end
            EXEC: begin
                if (ex_cnt == 4'd0) begin
                    jmp_lat_nx = jmp_req;
                    jmp_tgt_nx = jmp_addr;
                    state_nx   = UPDATE;
                end else begin
                    ex_cnt_nx = ex_cnt - 4'd1;
                end
            end
            UPDATE: begin
                if (jmp_lat) begin
                    pc_pen_n = 1'b0;
                    pc_d     = jmp_tgt;
                end else begin
                    pc_cep = 1'b1;
                    if (pc_q == 8'hFF) wrap_nx = 1'b1;
                end
                state_nx = halt_req ? HALT : FETCH;
            end
            HALT: begin
                if (run && !halt_req && !err) state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pc_cet  = pc_cep;
    assign state_o = state;
    assign ir_o    = ir;
    assign err_o   = err;
    assign wrap_o  = wrap;

endmodule
